lfsr10_stream_checker: RTL and testbench

//  Receive-side checker for the 10-bit XNOR LFSR random source (update: ps <= {ps[0]~^ps[3], ps[9:1]}).

---
 rtl/lfsr10_pkg.sv | 15 +
 rtl/lfsr10_stream_checker.sv | 127 ++++++++++++
 tb/tb_lfsr10_stream_checker.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/lfsr10_pkg.sv
// rtl/lfsr10_pkg.sv - shared constants, state type and reference step for the 10-bit XNOR LFSR
package lfsr10_pkg;

  localparam int LFSR_W = 10;
  localparam int TAP_A  = 0;
  localparam int TAP_B  = 3;
  localparam logic [LFSR_W-1:0] LOCKUP_STATE = 10'h3FF;

  typedef enum logic [1:0] {S_FILL, S_TRAIN, S_LOCK} chk_state_t;

  function automatic logic [LFSR_W-1:0] lfsr10_next(input logic [LFSR_W-1:0] ps);
    return {ps[TAP_A] ~^ ps[TAP_B], ps[LFSR_W-1:1]};
  endfunction

endpackage

// File: rtl/lfsr10_stream_checker.sv
// rtl/lfsr10_stream_checker.sv - self-synchronising checker for the 10-bit XNOR LFSR serial stream
// Always shifts in the received bit, so a corrupted bit echoes as mispredictions 7 and 10 bits later.
module lfsr10_stream_checker
  import lfsr10_pkg::*;
#(
  parameter int LOCK_COUNT = 16,
  parameter int MAX_ERRS   = 3,
  parameter int ERR_W      = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             bit_valid,
  input  logic             bit_in,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic [9:0]       lfsr_state,
  output logic             stuck
);

  localparam logic [7:0] GOOD_LAST = 8'(LOCK_COUNT - 1);
  localparam logic [7:0] BAD_LAST  = 8'(MAX_ERRS - 1);

  chk_state_t        state, state_n;
  logic [LFSR_W-1:0] hist, hist_n, hist_d;
  logic [3:0]        fill_cnt, fill_d;
  logic [7:0]        good_cnt, good_d;
  logic [7:0]        bad_cnt, bad_d;
  logic              pred, match, lockup;
  logic              locked_d, err_pulse_d, stuck_d;
  logic [ERR_W-1:0]  err_count_d;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state     <= S_FILL;
      hist      <= '0;
      fill_cnt  <= '0;
      good_cnt  <= '0;
      bad_cnt   <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      err_count <= '0;
      stuck     <= 1'b0;
    end else begin
      state     <= state_n;
      hist      <= hist_d;
      fill_cnt  <= fill_d;
      good_cnt  <= good_d;
      bad_cnt   <= bad_d;
      locked    <= locked_d;
      err_pulse <= err_pulse_d;
      err_count <= err_count_d;
      stuck     <= stuck_d;
    end
  end

  // Prediction uses the history before this bit is shifted in.
  always_comb begin
    pred    = hist[TAP_A] ~^ hist[TAP_B];
    match   = (bit_in == pred);
    hist_n  = {bit_in, hist[LFSR_W-1:1]};
    lockup  = (hist_n == LOCKUP_STATE);
    state_n = state;
    if (bit_valid) begin
      case (state)
        S_FILL:  if (fill_cnt == 4'd9) state_n = S_TRAIN;
        S_TRAIN: if (!lockup && match && good_cnt == GOOD_LAST) state_n = S_LOCK;
        S_LOCK: begin
          if (lockup) state_n = S_TRAIN;
          else if (!match && bad_cnt == BAD_LAST) state_n = S_TRAIN;
        end
        default: state_n = S_FILL;
      endcase
    end
  end

  always_comb begin
    hist_d      = hist;
    fill_d      = fill_cnt;
    good_d      = good_cnt;
    bad_d       = bad_cnt;
    err_pulse_d = 1'b0;
    err_count_d = err_count;
    stuck_d     = stuck;
    locked_d    = (state_n == S_LOCK);
    if (bit_valid) begin
      hist_d  = hist_n;
      stuck_d = (state != S_FILL) && lockup;
      case (state)
        S_FILL: begin
          fill_d = (fill_cnt == 4'd9) ? 4'd0 : fill_cnt + 4'd1;
          good_d = 8'd0;
          bad_d  = 8'd0;
        end
        S_TRAIN: begin
          bad_d  = 8'd0;
          good_d = (lockup || !match) ? 8'd0 : good_cnt + 8'd1;
        end
        S_LOCK: begin
          // A lock-up history drops lock silently; it is not counted as a link error.
          if (lockup) begin
            good_d = 8'd0;
            bad_d  = 8'd0;
          end else if (match) begin
            bad_d = 8'd0;
          end else begin
            err_pulse_d = 1'b1;
            if (err_count != '1) err_count_d = err_count + ERR_W'(1);
            if (bad_cnt == BAD_LAST) begin
              bad_d  = 8'd0;
              good_d = 8'd0;
            end else begin
              bad_d = bad_cnt + 8'd1;
            end
          end
        end
        default: begin
          good_d = 8'd0;
          bad_d  = 8'd0;
        end
      endcase
    end
  end

  assign lfsr_state = hist;

endmodule

// File: tb/tb_lfsr10_stream_checker.sv
// tb/tb_lfsr10_stream_checker.sv - directed bench for lfsr10_stream_checker against a golden LFSR source
module tb_lfsr10_stream_checker;
  import lfsr10_pkg::*;

  logic        Clock;
  logic        Reset;
  logic        bit_valid;
  logic        bit_in;
  logic        locked;
  logic        err_pulse;
  logic [15:0] err_count;
  logic [9:0]  lfsr_state;
  logic        stuck;

  logic        gb  [0:511];
  logic [9:0]  gps [0:511];
  int          n;
  int          k;
  int          checks = 0;
  int          errors = 0;

  lfsr10_stream_checker #(.LOCK_COUNT(16), .MAX_ERRS(3), .ERR_W(16)) dut (
    .Clock(Clock), .Reset(Reset), .bit_valid(bit_valid), .bit_in(bit_in),
    .locked(locked), .err_pulse(err_pulse), .err_count(err_count),
    .lfsr_state(lfsr_state), .stuck(stuck)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    Reset = 1'b1; bit_valid = 1'b0; bit_in = 1'b0;
    @(posedge Clock); #1;
    Reset = 1'b0;
    n = 0;
  endtask

  task automatic tx(input logic inv);
    bit_valid = 1'b1; bit_in = gb[n] ^ inv;
    @(posedge Clock); #1;
    n++;
  endtask

  task automatic idle();
    bit_valid = 1'b0;
    @(posedge Clock); #1;
  endtask

  initial begin
    logic [9:0] ps;
    ps = '0;
    for (int i = 0; i < 512; i++) begin
      gps[i] = ps;
      gb[i]  = ps[0];
      ps     = lfsr10_next(ps);
    end
    Reset = 1'b1; bit_valid = 1'b0; bit_in = 1'b0; n = 0;

    // 1: clean stream from source reset
    do_reset();
    check("rst_locked", locked, 0);
    check("rst_err_pulse", err_pulse, 0);
    check("rst_err_count", err_count, 0);
    check("rst_lfsr_state", lfsr_state, 0);
    check("rst_stuck", stuck, 0);
    check("src_b0_9_zero", {gb[0], gb[1], gb[2], gb[3], gb[4], gb[5], gb[6], gb[7], gb[8], gb[9]}, 0);
    check("src_b10_12_one", {gb[10], gb[11], gb[12]}, 3'b111);
    for (int i = 0; i < 26; i++) begin
      tx(1'b0);
      if (n >= 10) check("t1_lfsr_state", lfsr_state, gps[n-10]);
      if (i == 24) check("t1_locked_before", locked, 0);
    end
    check("t1_locked", locked, 1);
    check("t1_err_count", err_count, 0);

    // 2: single inverted bit echoes 7 and 10 bits later, lock held
    k = n;
    while (gb[k] != 1'b1 && k < 400) k++;
    while (n < k) tx(1'b0);
    for (int off = 0; off < 20; off++) begin
      tx(off == 0);
      check("t2_err_pulse", err_pulse, (off == 0 || off == 7 || off == 10));
      check("t2_locked", locked, 1);
      if (off == 0) check("t2_err_count_first", err_count, 1);
    end
    check("t2_err_count", err_count, 3);

    // 3: three consecutive inverted bits drop lock, relock after 16 good bits
    k = n;
    while (!(gb[k] && gb[k+1] && gb[k+2]) && k < 400) k++;
    while (n < k) tx(1'b0);
    for (int off = 0; off < 29; off++) begin
      tx(off < 3);
      if (off < 3) check("t3_err_pulse", err_pulse, 1);
      else         check("t3_no_pulse", err_pulse, 0);
      check("t3_locked", locked, (off < 2 || off == 28));
    end
    check("t3_err_count", err_count, 6);

    // 4: constant ones park the history in the lock-up state
    do_reset();
    for (int i = 1; i <= 25; i++) begin
      bit_valid = 1'b1; bit_in = 1'b1;
      @(posedge Clock); #1;
      check("t4_locked", locked, 0);
      if (i == 10) check("t4_stuck_fill", stuck, 0);
      if (i >= 11) check("t4_stuck", stuck, 1);
    end
    check("t4_err_count", err_count, 0);
    check("t4_lfsr_state", lfsr_state, 10'h3FF);

    // 5: bit_valid alternating
    do_reset();
    for (int i = 0; i < 26; i++) begin
      tx(1'b0);
      check("t5_locked_v", locked, (n >= 26));
      idle();
      check("t5_locked_idle", locked, (n >= 26));
      check("t5_pulse_idle", err_pulse, 0);
      if (n >= 10) check("t5_state_idle", lfsr_state, gps[n-10]);
    end

    // 6: five counted errors, then reset while locked
    do_reset();
    for (int i = 0; i < 30; i++) tx(1'b0);
    check("t6_locked", locked, 1);
    k = n;
    while (!(gb[k] && gb[k+3] && gb[k+13]) && k < 400) k++;
    while (n < k) tx(1'b0);
    for (int off = 0; off < 25; off++) begin
      tx(off == 0 || off == 3 || off == 13);
      check("t6_err_pulse", err_pulse, (off == 0 || off == 3 || off == 7 || off == 20 || off == 23));
    end
    check("t6_err_count", err_count, 5);
    check("t6_locked_held", locked, 1);
    do_reset();
    check("t6_rst_locked", locked, 0);
    check("t6_rst_err_count", err_count, 0);
    check("t6_rst_lfsr_state", lfsr_state, 0);
    check("t6_rst_stuck", stuck, 0);
    check("t6_rst_err_pulse", err_pulse, 0);
    for (int i = 0; i < 26; i++) begin
      tx(1'b0);
      if (i == 24) check("t6_relock_before", locked, 0);
    end
    check("t6_relock", locked, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
